status_cond_unit: RTL

Architectural status register and condition-evaluation unit for the 5-stage ARM core. It consumes the ALU's `{z, c, n, v}` status bits from the EXE stage and latches them when the EXE instruction has its S bit set. It forwards those flags to the ID-stage instruction and evaluates that instruction's 4-bit condition field. It then registers a per-instruction execute predicate into EXE, drives the carry-in back to the ALU, and keeps a saturating count of condition-annulled instructions.

---
 rtl/status_cond_unit_pkg.sv | 44 ++++
 rtl/status_cond_unit_cond.sv | 44 ++++
 rtl/status_cond_unit.sv | 69 ++++++
 3 files changed

// File: rtl/status_cond_unit_pkg.sv
// Shared constants for the core: ALU command codes, status bit positions
// and the ARM condition-field encodings.
package status_cond_unit_pkg;

    // ALU command codes driven by the decoder.
    typedef enum logic [3:0] {
        ALU_MOV = 4'd1,
        ALU_MVN = 4'd9,
        ALU_ADD = 4'd2,
        ALU_ADC = 4'd3,
        ALU_SUB = 4'd4,
        ALU_SBC = 4'd5,
        ALU_AND = 4'd6,
        ALU_ORR = 4'd7,
        ALU_EOR = 4'd8
    } alu_cmd_e;

    // Bit positions inside the {z, c, n, v} status vector.
    localparam int Z_BIT = 3;
    localparam int C_BIT = 2;
    localparam int N_BIT = 1;
    localparam int V_BIT = 0;

    // Instruction condition field [31:28].
    typedef enum logic [3:0] {
        EQ_COND = 4'd0,
        NE_COND = 4'd1,
        CS_COND = 4'd2,
        CC_COND = 4'd3,
        MI_COND = 4'd4,
        PL_COND = 4'd5,
        VS_COND = 4'd6,
        VC_COND = 4'd7,
        HI_COND = 4'd8,
        LS_COND = 4'd9,
        GE_COND = 4'd10,
        LT_COND = 4'd11,
        GT_COND = 4'd12,
        LE_COND = 4'd13,
        AL_COND = 4'd14,
        NV_COND = 4'd15
    } cond_e;

endpackage

// File: rtl/status_cond_unit_cond.sv
// cond_check: combinational evaluation of a 4-bit condition field against
// a {z, c, n, v} flag vector.
//   cond  in  4  condition field
//   flags in  4  status flags {z, c, n, v}
//   pass  out 1  condition holds
module cond_check
    import status_cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic z, c, n, v;

    assign z = flags[Z_BIT];
    assign c = flags[C_BIT];
    assign n = flags[N_BIT];
    assign v = flags[V_BIT];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            EQ_COND: pass = z;
            NE_COND: pass = !z;
            CS_COND: pass = c;
            CC_COND: pass = !c;
            MI_COND: pass = n;
            PL_COND: pass = !n;
            VS_COND: pass = v;
            VC_COND: pass = !v;
            HI_COND: pass = c & !z;
            LS_COND: pass = !c | z;
            GE_COND: pass = (n == v);
            LT_COND: pass = (n != v);
            GT_COND: pass = !z & (n == v);
            LE_COND: pass = z | (n != v);
            AL_COND: pass = 1'b1;
            NV_COND: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_cond_unit.sv
// status_cond_unit: architectural status register, flag forwarding to the
// ID stage, condition evaluation, EXE predicate register and a saturating
// count of condition-annulled instructions.
//   clk, rst_n     clock, async active-low reset
//   status_bits    ALU flags {z, c, n, v} from EXE
//   s_exe          EXE instruction writes flags this cycle
//   cond_id        ID instruction condition field
//   valid_id       ID holds a real instruction
//   stall, flush   ID freeze / squash (either one inserts a bubble into EXE)
//   sr, cin        status register and ALU carry-in
//   flags_id       forwarded flags seen by ID
//   cond_pass_id   combinational condition result for ID
//   cond_pass_exe  registered execute predicate for EXE
//   annul_cnt      saturating count of annulled valid instructions
module status_cond_unit
    import status_cond_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       status_bits,
    input  logic             s_exe,
    input  logic [3:0]       cond_id,
    input  logic             valid_id,
    input  logic             stall,
    input  logic             flush,
    output logic [3:0]       sr,
    output logic             cin,
    output logic [3:0]       flags_id,
    output logic             cond_pass_id,
    output logic             cond_pass_exe,
    output logic [CNT_W-1:0] annul_cnt
);

    logic advance;
    logic annul;

    // The EXE writer is older than the ID instruction, so ID must see its flags.
    assign flags_id = s_exe ? status_bits : sr;
    assign cin      = sr[C_BIT];

    cond_check u_cond_check (
        .cond  (cond_id),
        .flags (flags_id),
        .pass  (cond_pass_id)
    );

    assign advance = !stall && !flush;
    assign annul   = valid_id && advance && !cond_pass_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr            <= 4'b0000;
            cond_pass_exe <= 1'b0;
            annul_cnt     <= '0;
        end else begin
            // The EXE instruction always proceeds, so stall/flush never block the write.
            if (s_exe)
                sr <= status_bits;

            cond_pass_exe <= advance && valid_id && cond_pass_id;

            if (annul && (annul_cnt != {CNT_W{1'b1}}))
                annul_cnt <= annul_cnt + 1'b1;
        end
    end

endmodule
